// File: rtl/apb4_timer.sv
// apb4_timer: APB4 general-purpose timer (prescaler, compare match, one-shot/auto-reload, level irq).
// Define APB4_TIMER_CAPTURE_EN to add the cap_i input-capture channel (CAP register, CAPIF, CAPIE).
module apb4_timer #(
   parameter int CNT_WIDTH = 32,
   parameter int PSC_WIDTH = 16
) (
   input  logic        pclk,
   input  logic        presetn,
   input  logic [31:0] paddr,
   input  logic [2:0]  pprot,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [31:0] pwdata,
   input  logic [3:0]  pstrb,
   output logic        pready,
   output logic [31:0] prdata,
   output logic        pslverr,
`ifdef APB4_TIMER_CAPTURE_EN
   input  logic        cap_i,
`endif
   output logic        irq_o
);
   localparam logic [2:0] OFF_CTRL = 3'd0;
   localparam logic [2:0] OFF_PSCR = 3'd1;
   localparam logic [2:0] OFF_CNT  = 3'd2;
   localparam logic [2:0] OFF_CMP  = 3'd3;
   localparam logic [2:0] OFF_STAT = 3'd4;
   localparam logic [2:0] OFF_CAP  = 3'd5;

   logic                 en, ie, oneshot, capie, mif, capif;
   logic [PSC_WIDTH-1:0] pscr, pcnt;
   logic [CNT_WIDTH-1:0] cnt, cmp, cap;
   logic [2:0]           offset;
   logic                 access, err, wr;
   logic                 wr_ctrl, wr_pscr, wr_cnt, wr_cmp, wr_stat;
   logic                 sw_stop, tick, match;
   logic [31:0]          reg_val, bmask, wdata_m;
   logic                 unused_ok;

   assign unused_ok = ^{pprot, paddr[31:5], paddr[1:0]};

   assign offset = paddr[4:2];
   assign access = psel & penable;
   assign pready = 1'b1;

   always_comb begin
      err = 1'b0;
      if (offset > OFF_CAP) begin
         err = 1'b1;
      end else if (offset == OFF_CAP) begin
`ifdef APB4_TIMER_CAPTURE_EN
         err = pwrite;
`else
         err = 1'b1;
`endif
      end
   end

   assign pslverr = access & err;
   assign wr      = access & pwrite & ~err;
   assign wr_ctrl = wr & (offset == OFF_CTRL);
   assign wr_pscr = wr & (offset == OFF_PSCR);
   assign wr_cnt  = wr & (offset == OFF_CNT);
   assign wr_cmp  = wr & (offset == OFF_CMP);
   assign wr_stat = wr & (offset == OFF_STAT);

   always_comb begin
      reg_val = '0;
      case (offset)
         OFF_CTRL: reg_val = {28'd0, capie, oneshot, ie, en};
         OFF_PSCR: reg_val = 32'(pscr);
         OFF_CNT:  reg_val = 32'(cnt);
         OFF_CMP:  reg_val = 32'(cmp);
         OFF_STAT: reg_val = {30'd0, capif, mif};
         OFF_CAP:  reg_val = 32'(cap);
         default:  reg_val = '0;
      endcase
   end

   assign prdata  = (access & ~pwrite & ~err) ? reg_val : '0;

   // Byte-lane merge of write data into the currently addressed register.
   assign bmask   = {{8{pstrb[3]}}, {8{pstrb[2]}}, {8{pstrb[1]}}, {8{pstrb[0]}}};
   assign wdata_m = (reg_val & ~bmask) | (pwdata & bmask);

   // A same-cycle software disable suppresses the tick; a CNT write suppresses the match.
   assign sw_stop = wr_ctrl & ~wdata_m[0];
   assign tick    = en & (pcnt == pscr) & ~sw_stop;
   assign match   = tick & ~wr_cnt & (cnt == cmp);

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         en      <= 1'b0;
         ie      <= 1'b0;
         oneshot <= 1'b0;
         pscr    <= '0;
         pcnt    <= '0;
         cnt     <= '0;
         cmp     <= '0;
         mif     <= 1'b0;
         irq_o   <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            en      <= wdata_m[0];
            ie      <= wdata_m[1];
            oneshot <= wdata_m[2];
         end
         if (match && oneshot) en <= 1'b0;

         if (wr_pscr) pscr <= wdata_m[PSC_WIDTH-1:0];
         if (!en || wr_pscr || (pcnt == pscr)) pcnt <= '0;
         else                                  pcnt <= pcnt + PSC_WIDTH'(1);

         if (wr_cnt)     cnt <= wdata_m[CNT_WIDTH-1:0];
         else if (match) cnt <= '0;
         else if (tick)  cnt <= cnt + CNT_WIDTH'(1);

         if (wr_cmp) cmp <= wdata_m[CNT_WIDTH-1:0];

         mif   <= (mif & ~(wr_stat & pwdata[0] & pstrb[0])) | match;
         irq_o <= (ie & mif) | (capie & capif);
      end
   end

`ifdef APB4_TIMER_CAPTURE_EN
   logic [2:0] cap_sync;
   logic       cap_edge;

   // Two synchronizer stages, third stage only remembers the previous level.
   assign cap_edge = cap_sync[1] & ~cap_sync[2];

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         cap_sync <= '0;
         capie    <= 1'b0;
         capif    <= 1'b0;
         cap      <= '0;
      end else begin
         cap_sync <= {cap_sync[1:0], cap_i};
         if (wr_ctrl) capie <= wdata_m[3];
         capif <= (capif & ~(wr_stat & pwdata[1] & pstrb[0])) | cap_edge;
         if (cap_edge) cap <= cnt;
      end
   end
`else
   assign capie = 1'b0;
   assign capif = 1'b0;
   assign cap   = '0;
`endif

endmodule
